f_pc_queue: RTL and testbench
=============================

F_PC_QUEUE -- requirements
Module: f_pc_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch-request entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port g_flush  input  1  global pipeline flush.
REQ-005 SHALL have port in_valid  input  1  npc stage offers an entry.
REQ-006 SHALL have port in_ready  output  1  queue accepts an entry.
REQ-007 SHALL have port in_pc  input  32  fetch-block pc.
REQ-008 SHALL have port in_mask  input  2  slot-valid mask.
REQ-009 SHALL have port in_pred  input  predict_info_t  prediction info.
REQ-010 SHALL have port out_valid  output  1  head entry available to icache request stage.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head.
REQ-012 SHALL have ports out_pc  output  32, out_mask  output  2, out_pred  output  predict_info_t; head entry fields.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL store entries {pc, mask, pred} in a circular buffer; head/tail pointers are $clog2(DEPTH)+1 bits wide with a wrap bit.
REQ-015 SHALL treat full as equal index bits with differing wrap bits; empty as equal pointers.
REQ-016 SHALL drive in_ready = !full && !g_flush, from registered state only.
REQ-017 SHALL push on in_valid && in_ready: write tail entry, tail+1.
REQ-018 SHALL pop on out_valid && out_ready: head+1.
REQ-019 SHALL allow push and pop in the same cycle; count unchanged.
REQ-020 SHALL hold in_ready low when full even if out_ready is high; no full-state pass-through.
REQ-021 SHALL drive out_valid = !empty && !g_flush; out_* show the head entry.
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL deliver entries in push order; none dropped or duplicated absent flush.
REQ-024 SHALL wrap pointers modulo 2*DEPTH without special handling.
REQ-025 SHALL, on g_flush, ignore push/pop that cycle and clear head, tail and count at the next edge; all stored entries discarded.
REQ-026 SHALL have latency 1 cycle from accepted push to out_valid when empty (bypass off).
REQ-027 SHALL drive count_o = tail - head, range 0..DEPTH.
REQ-028 SHALL leave out_* undefined-but-unused when out_valid is low; bench does not check them.

Reset
REQ-029 SHALL, on rst asserted, asynchronously clear head, tail and count: out_valid=0, in_ready=1, count_o=0.
REQ-030 SHALL not require reset of the entry storage.
REQ-031 SHALL treat reset mid-operation as a full discard; first post-reset push lands in entry 0.

Configuration
REQ-032 SHALL support macro F_PCQ_BYPASS_EN.
REQ-033 SHALL, with F_PCQ_BYPASS_EN defined, present in_* on out_* combinationally when the queue is empty, in_valid is high and g_flush is low.
REQ-034 SHALL, in that bypass case with out_ready high, write nothing and leave pointers unchanged.
REQ-035 SHALL, in that bypass case with out_ready low, push normally.
REQ-036 SHALL, without F_PCQ_BYPASS_EN, register every entry; minimum latency 1 cycle.

Verification
REQ-037 SHALL cover: reset, push pc 0x1C000000 mask 11, out_ready=1 -> out_valid next cycle with pc 0x1C000000; count_o 1 then 0.
REQ-038 SHALL cover: DEPTH=4, out_ready=0, 5 pushes offered -> in_ready low after 4th, count_o=4, 5th held until pop, order preserved.
REQ-039 SHALL cover: full queue, in_valid=1, out_ready=1 for 8 cycles -> one pop per cycle, one push per non-full cycle, pointers wrap, no loss.
REQ-040 SHALL cover: 3 entries queued, g_flush 1 cycle -> that cycle out_valid=0, in_ready=0; next cycle count_o=0; next push pc 0x1C000040 emerges first.
REQ-041 SHALL cover: rst asserted mid-stream with 2 entries -> out_valid=0, count_o=0 immediately without clock edge.
REQ-042 SHALL cover: F_PCQ_BYPASS_EN, empty queue, in_valid=1, out_ready=1, pc 0x1C000008 mask 01 -> out_valid same cycle, out_pc 0x1C000008, count_o stays 0.

Source files
------------

// File: rtl/f_pc_queue.sv
// f_pc_queue: circular fetch-request queue between the npc stage and the icache request stage.
// Latency: 1 cycle from accepted push to out_valid (0 cycles through the empty-queue bypass when F_PCQ_BYPASS_EN is defined).
// Backpressure: in_ready drops when full or on g_flush and never passes through on a same-cycle pop; out_* hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst (async, active high)          - clock and reset
//   g_flush                                - discard all entries; push/pop ignored this cycle
//   in_valid/in_ready, in_pc/mask/pred     - entry offered by npc stage
//   out_valid/out_ready, out_pc/mask/pred  - head entry to icache request stage
//   count_o                                - occupancy, 0..DEPTH
// Optional feature macro: F_PCQ_BYPASS_EN (empty-queue combinational bypass).

package f_pc_queue_pkg;
  typedef struct packed {
    logic        taken;
    logic [1:0]  slot;
    logic [31:0] target;
  } predict_info_t;
endpackage

module f_pc_queue
  import f_pc_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     g_flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [1:0]               in_mask,
  input  predict_info_t            in_pred,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [1:0]               out_mask,
  output predict_info_t            out_pred,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [31:0]   pc;
    logic [1:0]    mask;
    predict_info_t pred;
  } entry_t;

  // Entry storage is never reset; only the pointers define what is valid.
  entry_t mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  entry_t        wr_ent;
  entry_t        head_ent;
`ifdef F_PCQ_BYPASS_EN
  logic          byp;
`endif

  always_comb begin
    empty    = (head_q == tail_q);
    // Same slot index but opposite wrap bits means the tail has lapped the head.
    full     = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    in_ready = !full && !g_flush;
    wr_ent   = '{pc: in_pc, mask: in_mask, pred: in_pred};
    head_ent = mem_q[head_q[IW-1:0]];

`ifdef F_PCQ_BYPASS_EN
    byp       = empty && in_valid && !g_flush;
    out_valid = (!empty || in_valid) && !g_flush;
    // A bypassed entry consumed in the same cycle never touches storage.
    push      = in_valid && in_ready && !(byp && out_ready);
    pop       = out_valid && out_ready && !empty;
    out_pc    = byp ? in_pc   : head_ent.pc;
    out_mask  = byp ? in_mask : head_ent.mask;
    out_pred  = byp ? in_pred : head_ent.pred;
`else
    out_valid = !empty && !g_flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_pc    = head_ent.pc;
    out_mask  = head_ent.mask;
    out_pred  = head_ent.pred;
`endif

    head_d = head_q;
    tail_d = tail_q;
    if (g_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
    end

    // Pointer difference modulo 2*DEPTH gives occupancy directly.
    count_o = tail_q - head_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q[IW-1:0]] <= wr_ent;
  end

endmodule

// File: tb/tb_f_pc_queue.sv
module tb_f_pc_queue;
  import f_pc_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef F_PCQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          g_flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [1:0]    in_mask;
  predict_info_t in_pred;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [1:0]    out_mask;
  predict_info_t out_pred;
  logic [2:0]    count_o;

  f_pc_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .g_flush(g_flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_mask(in_mask), .in_pred(in_pred),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_mask(out_mask), .out_pred(out_pred),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic [1:0]    mask;
    predict_info_t pred;
  } ent_t;

  ent_t model_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of stored entries, updated on each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
    end else if (g_flush) begin
      model_q.delete();
    end else begin
      automatic bit was_empty = (model_q.size() == 0);
      automatic bit bypassed  = BYP && was_empty && in_valid && out_ready;
      automatic bit do_pop    = !was_empty && out_ready;
      automatic bit do_push   = in_valid && (model_q.size() < DEPTH) && !bypassed;
      automatic ent_t e;
      e.pc = in_pc; e.mask = in_mask; e.pred = in_pred;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      automatic bit   has   = (model_q.size() != 0);
      automatic bit   e_ov  = !g_flush && (has || (BYP && in_valid));
      automatic bit   e_ir  = !g_flush && (model_q.size() < DEPTH);
      automatic ent_t h;
      chk("cyc_count", 64'(count_o), 64'(model_q.size()));
      chk("cyc_in_ready", 64'(in_ready), 64'(e_ir));
      chk("cyc_out_valid", 64'(out_valid), 64'(e_ov));
      if (e_ov) begin
        if (has) h = model_q[0];
        else begin h.pc = in_pc; h.mask = in_mask; h.pred = in_pred; end
        chk("cyc_out_pc", 64'(out_pc), 64'(h.pc));
        chk("cyc_out_mask", 64'(out_mask), 64'(h.mask));
        chk("cyc_out_pred", 64'(out_pred), 64'(h.pred));
      end
    end
  end

  logic [31:0] pc_next;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a stream of entries; the pc advances only once the current one is taken.
  task automatic stream(input int n, input logic ordy);
    for (int i = 0; i < n; i++) begin
      automatic logic acc;
      out_ready = ordy;
      in_valid  = 1'b1;
      in_pc     = pc_next;
      in_mask   = pc_next[3:2];
      in_pred   = '{taken: pc_next[2], slot: pc_next[5:4], target: pc_next + 32'h40};
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) pc_next = pc_next + 32'h4;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; g_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_mask = '0; in_pred = '0;
    pc_next = 32'h0000_0100;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    #9 rst = 1'b0;
    step();

    // Single entry through the queue.
    in_valid = 1'b1; in_pc = 32'h1C00_0000; in_mask = 2'b11;
    in_pred = '{taken: 1'b1, slot: 2'd1, target: 32'h1C00_0100};
    out_ready = 1'b1;
`ifndef F_PCQ_BYPASS_EN
    #1;
    chk("t1_pre_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", 64'(out_pc), 64'h1C00_0000);
    chk("t1_count1", 64'(count_o), 64'd1);
    step();
    chk("t1_count0", 64'(count_o), 64'd0);
`else
    out_ready = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
`endif

    // Fill to DEPTH with out_ready low; the 5th offer must be held.
    stream(4, 1'b0);
    chk("fill_count", 64'(count_o), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    stream(2, 1'b0);
    chk("fill_hold_count", 64'(count_o), 64'd4);
    chk("fill_hold_head", 64'(out_pc), 64'h0000_0100);

    // Full with out_ready high: pop but no push in that cycle, then steady flow with wrap.
    stream(1, 1'b1);
    chk("full_pop_count", 64'(count_o), 64'd3);
    chk("full_pop_head", 64'(out_pc), 64'h0000_0104);
    stream(8, 1'b1);
    out_ready = 1'b1;
    step(); step(); step(); step();
    chk("drain_count", 64'(count_o), 64'd0);

    // Flush with 3 entries queued.
    out_ready = 1'b0;
    stream(3, 1'b0);
    chk("pre_flush_count", 64'(count_o), 64'd3);
    g_flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD_0000;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    g_flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_flush_count", 64'(count_o), 64'd0);
    pc_next = 32'h1C00_0040;
    stream(1, 1'b0);
    chk("post_flush_pc", 64'(out_pc), 64'h1C00_0040);
    chk("post_flush_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset mid-stream with 2 entries.
    stream(1, 1'b0);
    chk("pre_rst_count", 64'(count_o), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    #3 rst = 1'b0;
    step();
    pc_next = 32'h1C00_0080;
    stream(2, 1'b0);
    chk("post_rst_pc", 64'(out_pc), 64'h1C00_0080);
    out_ready = 1'b1;
    step(); step(); step();

`ifdef F_PCQ_BYPASS_EN
    // Bypass: empty queue, entry offered and consumed in the same cycle.
    in_valid = 1'b1; in_pc = 32'h1C00_0008; in_mask = 2'b01; in_pred = '0;
    out_ready = 1'b1;
    #1;
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_pc", 64'(out_pc), 64'h1C00_0008);
    chk("byp_mask", 64'(out_mask), 64'd1);
    chk("byp_count", 64'(count_o), 64'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("byp_after_count", 64'(count_o), 64'd0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
